// File: rtl/kf76489_write_sequencer_if.sv
// Request and chip-side bus of the KF76489 write sequencer.
// The master side is the requesters plus the PSG; the slave side is the sequencer.
interface kf76489_write_sequencer_if;
   logic [1:0]       req_valid;
   logic [1:0][2:0]  req_addr;
   logic [1:0][9:0]  req_data;
   logic [1:0]       req_ready;
   logic             READY;
   logic             CE_N;
   logic             WE_N;
   logic [7:0]       D_OUT;
   logic             busy;
   logic             grant_id;

   modport master (
      output req_valid, req_addr, req_data, READY,
      input  req_ready, CE_N, WE_N, D_OUT, busy, grant_id
   );

   modport slave (
      input  req_valid, req_addr, req_data, READY,
      output req_ready, CE_N, WE_N, D_OUT, busy, grant_id
   );
endinterface

// File: rtl/kf76489_write_sequencer.sv
// Round-robin write sequencer for the KF76489 PSG: arbitrates two requesters,
// encodes each register write into one or two bytes and strobes them out.
module kf76489_write_sequencer #(
   parameter int MIN_STROBE = 64,
   parameter int GAP        = 2
) (
   input logic                      clock,
   input logic                      reset,
   kf76489_write_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

   localparam logic [7:0] STROBE_MIN = 8'(MIN_STROBE);
   localparam logic [3:0] GAP_LEN    = 4'(GAP);

   state_t      state_reg, state_next;
   logic [7:0]  strobe_cnt_reg, strobe_cnt_next;
   logic [3:0]  gap_cnt_reg, gap_cnt_next;
   logic        byte_idx_reg, byte_idx_next;
   logic        rr_reg;
   logic        grant_reg;
   logic [2:0]  addr_reg;
   logic [9:0]  data_reg;
   logic        ce_n_reg;

   logic        sel;
   logic        accept;
   logic        two_byte;
   logic [7:0]  cur_byte;

   // A lone requester always wins; the pointer only breaks ties.
   always_comb begin
      sel = rr_reg;
      if (bus.req_valid == 2'b01)
         sel = 1'b0;
      else if (bus.req_valid == 2'b10)
         sel = 1'b1;
   end

   assign accept = (state_reg == IDLE) && !reset && (bus.req_valid != 2'b00);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign bus.req_ready[gi] = accept && (sel == 1'(gi));
      end
   endgenerate

   function automatic logic [7:0] encode(input logic [2:0] a, input logic [9:0] d,
                                         input logic second);
      logic [3:0] reg_field;
      reg_field = {a[0], a[1], a[2], 1'b1};
      if (second)
         return {d[4], d[5], d[6], d[7], d[8], d[9], 2'b00};
      if (a == 3'd6)
         return {d[1], d[0], d[2], 1'b0, reg_field};
      return {d[0], d[1], d[2], d[3], reg_field};
   endfunction

   assign two_byte = !addr_reg[0] && (addr_reg != 3'd6);
   assign cur_byte = encode(addr_reg, data_reg, byte_idx_reg);

   always_comb begin
      state_next      = state_reg;
      strobe_cnt_next = strobe_cnt_reg;
      gap_cnt_next    = gap_cnt_reg;
      byte_idx_next   = byte_idx_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next    = SETUP;
               byte_idx_next = 1'b0;
            end
         end
         SETUP: begin
            state_next      = STROBE;
            strobe_cnt_next = 8'd1;
         end
         STROBE: begin
            if (strobe_cnt_reg >= STROBE_MIN && bus.READY) begin
               state_next   = RELEASE;
               gap_cnt_next = 4'd1;
            end else if (strobe_cnt_reg != 8'hFF) begin
               strobe_cnt_next = strobe_cnt_reg + 8'd1;
            end
         end
         RELEASE: begin
            if (gap_cnt_reg >= GAP_LEN) begin
               // The data byte follows without returning to IDLE, so no other
               // requester can slip in between latch and data byte.
               if (two_byte && !byte_idx_reg) begin
                  state_next    = SETUP;
                  byte_idx_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               gap_cnt_next = gap_cnt_reg + 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         strobe_cnt_reg <= 8'd0;
         gap_cnt_reg    <= 4'd0;
         byte_idx_reg   <= 1'b0;
         rr_reg         <= 1'b0;
         grant_reg      <= 1'b0;
         addr_reg       <= 3'd0;
         data_reg       <= 10'd0;
         ce_n_reg       <= 1'b1;
      end else begin
         state_reg      <= state_next;
         strobe_cnt_reg <= strobe_cnt_next;
         gap_cnt_reg    <= gap_cnt_next;
         byte_idx_reg   <= byte_idx_next;
         // Registered strobe keeps CE_N/WE_N glitch-free across state changes.
         ce_n_reg       <= (state_next != STROBE);
         if (accept) begin
            addr_reg  <= bus.req_addr[sel];
            data_reg  <= bus.req_data[sel];
            grant_reg <= sel;
            rr_reg    <= ~sel;
         end
      end
   end

   assign bus.CE_N     = ce_n_reg;
   assign bus.WE_N     = ce_n_reg;
   assign bus.D_OUT    = (state_reg == IDLE) ? 8'hFF : cur_byte;
   assign bus.busy     = (state_reg != IDLE);
   assign bus.grant_id = grant_reg;
endmodule
